edge_bbox_overlay: RTL and testbench
====================================

Name: edge_bbox_overlay

Overview:
- Downstream consumer of the Sobel binary edge stream (vsync/href/de + 1-bit pixel).
- Per frame: tracks the bounding box of edge pixels inside a border-cropped window and counts them.
- Publishes the box, count and a one-cycle valid pulse at frame end.
- Re-emits the video as RGB565: edge pixels black on white, with the previous frame's box drawn in red. Output feeds the LCD path.

Parameters:
- IMG_W, 640, active pixels per line.
- IMG_H, 480, active lines per frame.
- COORD_W, 11, coordinate width in bits.
- BORDER, 2, pixels excluded at each image edge (suppresses Sobel edge artefacts).
- MIN_EDGE_CNT, 64, minimum in-window edge pixels for a box to count as found.
- BOX_COLOR, 16'hF800, RGB565 colour of the overlay.

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset, asynchronous, active-high
- pre_frame_vsync  in  1  frame valid, high during frame
- pre_frame_href  in  1  line valid
- pre_frame_de  in  1  pixel valid
- pre_img_bit  in  1  1 = edge pixel
- post_frame_vsync  out  1  pre_frame_vsync delayed 1 cycle
- post_frame_href  out  1  pre_frame_href delayed 1 cycle
- post_frame_de  out  1  pre_frame_de delayed 1 cycle
- post_rgb  out  16  RGB565 output pixel
- box_x_min  out  COORD_W  box left coordinate
- box_x_max  out  COORD_W  box right coordinate
- box_y_min  out  COORD_W  box top coordinate
- box_y_max  out  COORD_W  box bottom coordinate
- edge_cnt  out  21  in-window edge pixel count of the last frame, saturating
- box_found  out  1  last frame had edge_cnt >= MIN_EDGE_CNT
- box_valid  out  1  one-cycle pulse when the box outputs update

Behaviour:
- Reset (async, rst=1): every output is 0, FSM = IDLE, all counters and accumulators are cleared. box_found=0 disables the overlay.
- Coordinates:
  - x = number of de cycles since href rose. It is 0 for the first pixel, increments after each de pixel and clears on href falling.
  - y = number of completed lines since vsync rose. It increments on href falling and clears on vsync rising.
  - Both counters saturate at 2^COORD_W-1 and never wrap.
- A pixel is in-window when BORDER <= x < IMG_W-BORDER and BORDER <= y < IMG_H-BORDER. Pixels with de=0 are ignored.
- FSM:
  - IDLE: on registered vsync rising edge, clear the accumulators (x_min/y_min = all ones, x_max/y_max = 0, cnt = 0), go to ACTIVE.
  - ACTIVE: for each in-window pixel with bit=1, update min/max and increment cnt (saturating at 2^21-1). On vsync falling edge, go to DONE.
  - DONE (1 cycle):
    - Latch the outputs and pulse box_valid=1.
    - Set edge_cnt = cnt and box_found = (cnt >= MIN_EDGE_CNT).
    - If found, box_* = accumulators; otherwise box_* = 0.
    - Next state is ACTIVE if a vsync rising edge is seen in this same cycle (accumulators cleared), else IDLE.
- box_valid fires exactly 1 cycle after the cycle in which vsync is sampled low following high.
- Box outputs hold until the next DONE.
- Overlay (1-cycle registered pipeline):
  - Perimeter pixel: box_found=1 and either
    - (x==box_x_min or x==box_x_max) with box_y_min <= y <= box_y_max, or
    - (y==box_y_min or y==box_y_max) with box_x_min <= x <= box_x_max.
  - post_rgb = BOX_COLOR on perimeter pixels, else {16{~pre_img_bit}}.
  - When de=0, post_rgb = 0.
- The overlay uses the box from the previous completed frame. A DONE update during vsync-low blanking takes effect from the next frame.
- Frame ending with vsync rising while in IDLE with no falling edge seen (e.g. after reset mid-frame): the FSM waits for the next rising edge. A partial frame never publishes.
- Reset mid-operation: outputs drop to 0 immediately. Recovery starts at the first full frame after rst deasserts.

Decomposition:
- Shared package vip_pkg holds:
  - COORD_W default;
  - RGB565 constants (BLACK 16'h0000, WHITE 16'hFFFF, RED 16'hF800);
  - FSM state encoding (IDLE, ACTIVE, DONE);
  - edge-count width.
- One sub-module, vip_pixel_coord: generates x/y from vsync/href/de plus registered edge strobes for vsync rising/falling and href falling. It is reusable by other vip stages.

Test Plan:
- Base configuration for all scenarios: IMG_W=16, IMG_H=12, BORDER=1, MIN_EDGE_CNT=2.
- Edge pixels at (3,2) and (9,7) -> box_valid high 1 cycle, 1 cycle after vsync falls; x 3..9, y 2..7; edge_cnt=2; box_found=1.
- Single edge pixel at (5,5) -> edge_cnt=1, box_found=0, all box_* = 0, box_valid still pulses.
- Edge pixels only at (0,0), (15,11) and (0,6) -> edge_cnt=0, box_found=0.
- Frame after scenario 1 with all bits 0:
  - post_rgb = 16'hF800 at (3..9,2), (3..9,7), (3,2..7), (9,2..7);
  - 16'hFFFF elsewhere during de;
  - 0 during blanking;
  - post_* syncs equal inputs delayed by exactly 1 cycle.
- rst asserted mid-ACTIVE with edges already seen -> all outputs 0 asynchronously; that frame never publishes; the next full frame reports correctly.
- de gaps inside href (pixels with de=0 but bit=1) -> not counted, x does not advance; box matches de-only pixels.

Source files
------------

// File: rtl/vip_pkg.sv
// vip_pkg: shared widths, RGB565 colours and FSM encoding for the vip video stages
package vip_pkg;
  localparam int COORD_W = 11;
  localparam int CNT_W = 21;
  localparam logic [15:0] RGB_BLACK = 16'h0000;
  localparam logic [15:0] RGB_WHITE = 16'hFFFF;
  localparam logic [15:0] RGB_RED = 16'hF800;
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} vip_state_e;
endpackage

// File: rtl/vip_pixel_coord.sv
// vip_pixel_coord: saturating pixel x/y counters and vsync edge strobes for a vsync/href/de stream
module vip_pixel_coord #(
  parameter int COORD_W = vip_pkg::COORD_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vsync,
  input  logic               href,
  input  logic               de,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               vs_rise,
  output logic               vs_fall
);
  localparam logic [COORD_W-1:0] SAT = '1;
  logic vs_d, href_d, href_fall;
  logic [COORD_W-1:0] x_q, y_q;
  assign vs_rise = vsync & ~vs_d;
  assign vs_fall = ~vsync & vs_d;
  assign href_fall = ~href & href_d;
  assign x = x_q;
  assign y = vs_rise ? '0 : y_q;
  // vs_d resets high so a frame already running when rst releases never looks like a new frame
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vs_d <= 1'b1;
      href_d <= 1'b0;
      x_q <= '0;
      y_q <= '0;
    end else begin
      vs_d <= vsync;
      href_d <= href;
      x_q <= href_fall ? '0 : (de && x_q != SAT) ? x_q + 1'b1 : x_q;
      y_q <= vs_rise ? '0 : (href_fall && y_q != SAT) ? y_q + 1'b1 : y_q;
    end
endmodule

// File: rtl/edge_bbox_overlay.sv
// edge_bbox_overlay: per-frame bounding box and count of edge pixels, RGB565 re-emission with the
// previous frame's box drawn on top
module edge_bbox_overlay #(
  parameter int          IMG_W        = 640,
  parameter int          IMG_H        = 480,
  parameter int          COORD_W      = vip_pkg::COORD_W,
  parameter int          BORDER       = 2,
  parameter int          MIN_EDGE_CNT = 64,
  parameter logic [15:0] BOX_COLOR    = vip_pkg::RGB_RED
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pre_frame_vsync,
  input  logic                      pre_frame_href,
  input  logic                      pre_frame_de,
  input  logic                      pre_img_bit,
  output logic                      post_frame_vsync,
  output logic                      post_frame_href,
  output logic                      post_frame_de,
  output logic [15:0]               post_rgb,
  output logic [COORD_W-1:0]        box_x_min,
  output logic [COORD_W-1:0]        box_x_max,
  output logic [COORD_W-1:0]        box_y_min,
  output logic [COORD_W-1:0]        box_y_max,
  output logic [vip_pkg::CNT_W-1:0] edge_cnt,
  output logic                      box_found,
  output logic                      box_valid
);
  import vip_pkg::*;
  localparam logic [COORD_W-1:0] X_LO = COORD_W'(BORDER);
  localparam logic [COORD_W-1:0] X_HI = COORD_W'(IMG_W - BORDER);
  localparam logic [COORD_W-1:0] Y_LO = COORD_W'(BORDER);
  localparam logic [COORD_W-1:0] Y_HI = COORD_W'(IMG_H - BORDER);
  localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_EDGE_CNT);
  logic [COORD_W-1:0] x, y;
  logic vs_rise, vs_fall;
  vip_state_e state, state_nxt;
  logic clear, accum, publish, hit, take, perim, found;
  logic [COORD_W-1:0] acc_x_min, acc_x_max, acc_y_min, acc_y_max;
  logic [COORD_W-1:0] base_x_min, base_x_max, base_y_min, base_y_max;
  logic [CNT_W-1:0] acc_cnt, base_cnt;
  vip_pixel_coord #(.COORD_W(COORD_W)) u_coord (
    .clk     (clk),
    .rst     (rst),
    .vsync   (pre_frame_vsync),
    .href    (pre_frame_href),
    .de      (pre_frame_de),
    .x       (x),
    .y       (y),
    .vs_rise (vs_rise),
    .vs_fall (vs_fall)
  );
  assign hit = pre_frame_de && pre_img_bit && x >= X_LO && x < X_HI && y >= Y_LO && y < Y_HI;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  // a new frame clears and accumulates in the same cycle, so its first pixel is never lost
  always_comb begin
    state_nxt = state;
    clear = 1'b0;
    accum = 1'b0;
    publish = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = vs_rise ? ACTIVE : IDLE;
        clear = vs_rise;
        accum = vs_rise;
      end
      ACTIVE: begin
        state_nxt = vs_fall ? DONE : ACTIVE;
        publish = vs_fall;
        accum = ~vs_fall;
      end
      DONE: begin
        state_nxt = vs_rise ? ACTIVE : IDLE;
        clear = vs_rise;
        accum = vs_rise;
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    base_x_min = clear ? '1 : acc_x_min;
    base_x_max = clear ? '0 : acc_x_max;
    base_y_min = clear ? '1 : acc_y_min;
    base_y_max = clear ? '0 : acc_y_max;
    base_cnt = clear ? '0 : acc_cnt;
    take = accum && hit;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc_x_min <= '0;
      acc_x_max <= '0;
      acc_y_min <= '0;
      acc_y_max <= '0;
      acc_cnt <= '0;
    end else begin
      acc_x_min <= (take && x < base_x_min) ? x : base_x_min;
      acc_x_max <= (take && x > base_x_max) ? x : base_x_max;
      acc_y_min <= (take && y < base_y_min) ? y : base_y_min;
      acc_y_max <= (take && y > base_y_max) ? y : base_y_max;
      acc_cnt <= (take && base_cnt != '1) ? base_cnt + 1'b1 : base_cnt;
    end
  assign found = acc_cnt >= CNT_MIN;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      box_valid <= 1'b0;
      box_found <= 1'b0;
      edge_cnt <= '0;
      box_x_min <= '0;
      box_x_max <= '0;
      box_y_min <= '0;
      box_y_max <= '0;
    end else begin
      box_valid <= publish;
      if (publish) begin
        edge_cnt <= acc_cnt;
        box_found <= found;
        box_x_min <= found ? acc_x_min : '0;
        box_x_max <= found ? acc_x_max : '0;
        box_y_min <= found ? acc_y_min : '0;
        box_y_max <= found ? acc_y_max : '0;
      end
    end
  // box registers only change during vsync-low blanking, so the overlay always shows the last full frame
  assign perim = box_found &&
    (((x == box_x_min || x == box_x_max) && y >= box_y_min && y <= box_y_max) ||
     ((y == box_y_min || y == box_y_max) && x >= box_x_min && x <= box_x_max));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      post_frame_vsync <= 1'b0;
      post_frame_href <= 1'b0;
      post_frame_de <= 1'b0;
      post_rgb <= '0;
    end else begin
      post_frame_vsync <= pre_frame_vsync;
      post_frame_href <= pre_frame_href;
      post_frame_de <= pre_frame_de;
      post_rgb <= !pre_frame_de ? '0 : perim ? BOX_COLOR : pre_img_bit ? RGB_BLACK : RGB_WHITE;
    end
endmodule

// File: tb/tb_edge_bbox_overlay.sv
// tb_edge_bbox_overlay: randomized frames against a frame-level reference model with a per-cycle scoreboard
module tb_edge_bbox_overlay;
  localparam int W = 16, H = 12, B = 1, MINC = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic vs = 1'b0, hs = 1'b0, de = 1'b0, bt = 1'b0;
  logic post_frame_vsync, post_frame_href, post_frame_de, box_found, box_valid;
  logic [15:0] post_rgb;
  logic [10:0] box_x_min, box_x_max, box_y_min, box_y_max;
  logic [20:0] edge_cnt;
  edge_bbox_overlay #(
    .IMG_W(W), .IMG_H(H), .COORD_W(11), .BORDER(B), .MIN_EDGE_CNT(MINC), .BOX_COLOR(16'hF800)
  ) dut (
    .clk(clk), .rst(rst),
    .pre_frame_vsync(vs), .pre_frame_href(hs), .pre_frame_de(de), .pre_img_bit(bt),
    .post_frame_vsync(post_frame_vsync), .post_frame_href(post_frame_href), .post_frame_de(post_frame_de),
    .post_rgb(post_rgb),
    .box_x_min(box_x_min), .box_x_max(box_x_max), .box_y_min(box_y_min), .box_y_max(box_y_max),
    .edge_cnt(edge_cnt), .box_found(box_found), .box_valid(box_valid)
  );
  always #5 clk = ~clk;
  typedef struct {
    int cyc;
    logic [2:0] sync;
    logic [15:0] rgb;
    logic [43:0] box;
    logic [20:0] cnt;
    logic found;
    logic valid;
  } exp_t;
  exp_t q[$];
  int cyc = 0, n_cmp = 0, n_bad = 0;
  logic mp [H][W];
  int px0, px1, py0, py1, pcnt;
  bit pfound, frame_full, prev_vs, rst_nxt;
  always @(posedge clk) cyc++;
  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, "_sync"}, 96'({post_frame_vsync, post_frame_href, post_frame_de}), 96'(0));
    chk({nm, "_rgb"}, 96'(post_rgb), 96'(0));
    chk({nm, "_box"}, 96'({box_x_min, box_x_max, box_y_min, box_y_max}), 96'(0));
    chk({nm, "_flags"}, 96'({edge_cnt, box_found, box_valid}), 96'(0));
  endtask
  // the published result is simply the edges inside the cropped window of the frame bitmap
  function automatic void publish();
    int c = 0, a0 = W, a1 = -1, b0 = H, b1 = -1;
    for (int r = B; r < H - B; r++)
      for (int k = B; k < W - B; k++)
        if (mp[r][k]) begin
          c++;
          if (k < a0) a0 = k;
          if (k > a1) a1 = k;
          if (r < b0) b0 = r;
          if (r > b1) b1 = r;
        end
    pcnt = c;
    pfound = c >= MINC;
    px0 = pfound ? a0 : 0;
    px1 = pfound ? a1 : 0;
    py0 = pfound ? b0 : 0;
    py1 = pfound ? b1 : 0;
  endfunction
  function automatic bit on_box(input int px, input int py);
    bit inside_rect = px >= px0 && px <= px1 && py >= py0 && py <= py1;
    return pfound && inside_rect && (px == px0 || px == px1 || py == py0 || py == py1);
  endfunction
  task automatic step(input logic v, input logic h, input logic d, input logic b, input int px, input int py);
    exp_t e;
    @(posedge clk);
    #1;
    rst = rst_nxt;
    vs = v;
    hs = h;
    de = d;
    bt = b;
    e.cyc = cyc + 1;
    e.sync = 3'b0;
    e.rgb = 16'h0;
    e.box = 44'h0;
    e.cnt = 21'h0;
    e.found = 1'b0;
    e.valid = 1'b0;
    if (rst) begin
      frame_full = 1'b0;
      prev_vs = 1'b1;
      pfound = 1'b0;
      {px0, px1, py0, py1, pcnt} = {32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    end else begin
      e.sync = {v, h, d};
      e.rgb = !d ? 16'h0 : on_box(px, py) ? 16'hF800 : (b ? 16'h0000 : 16'hFFFF);
      if (v && !prev_vs) frame_full = 1'b1;
      if (!v && prev_vs) begin
        if (frame_full) begin
          publish();
          e.valid = 1'b1;
        end
        frame_full = 1'b0;
      end
      e.box = {11'(px0), 11'(px1), 11'(py0), 11'(py1)};
      e.cnt = 21'(pcnt);
      e.found = pfound;
      prev_vs = v;
    end
    q.push_back(e);
  endtask
  task automatic do_reset();
    #2;
    rst = 1'b1;
    rst_nxt = 1'b1;
    #1;
    chk_zero("midrst");
    q.delete();
    repeat (2) step(1, 0, 0, 0, 0, 0);
    rst_nxt = 1'b0;
  endtask
  task automatic send_frame(input bit gaps, input int rst_line);
    repeat (2) step(1, 0, 0, 0, 0, 0);
    for (int ly = 0; ly < H; ly++) begin
      if (ly == rst_line) do_reset();
      for (int lx = 0; lx < W; lx++) begin
        if (gaps) repeat ($urandom_range(0, 2)) step(1, 1, 0, 1, lx, ly);
        step(1, 1, 1, mp[ly][lx], lx, ly);
      end
      repeat (2) step(1, 0, 0, 0, 0, 0);
    end
    repeat ($urandom_range(1, 4)) step(0, 0, 0, 0, 0, 0);
  endtask
  task automatic clear_map();
    for (int r = 0; r < H; r++)
      for (int k = 0; k < W; k++) mp[r][k] = 1'b0;
  endtask
  task automatic rand_map(input int dens);
    for (int r = 0; r < H; r++)
      for (int k = 0; k < W; k++) mp[r][k] = $urandom_range(0, 99) < dens;
  endtask
  always @(negedge clk) begin : monitor
    exp_t e;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      chk("stale_entry", 96'(e.cyc), 96'(cyc));
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      chk("sync", 96'({post_frame_vsync, post_frame_href, post_frame_de}), 96'(e.sync));
      chk("rgb", 96'(post_rgb), 96'(e.rgb));
      chk("box", 96'({box_x_min, box_x_max, box_y_min, box_y_max}), 96'(e.box));
      chk("edge_cnt", 96'(edge_cnt), 96'(e.cnt));
      chk("box_found", 96'(box_found), 96'(e.found));
      chk("box_valid", 96'(box_valid), 96'(e.valid));
    end
  end
  initial begin
    rst_nxt = 1'b1;
    prev_vs = 1'b1;
    #3;
    chk_zero("reset");
    repeat (3) step(0, 0, 0, 0, 0, 0);
    rst_nxt = 1'b0;
    repeat (3) step(0, 0, 0, 0, 0, 0);
    clear_map(); mp[2][3] = 1'b1; mp[7][9] = 1'b1; send_frame(0, -1);
    clear_map(); send_frame(0, -1);
    clear_map(); mp[5][5] = 1'b1; send_frame(0, -1);
    clear_map(); mp[0][0] = 1'b1; mp[11][15] = 1'b1; mp[6][0] = 1'b1; send_frame(0, -1);
    clear_map(); mp[2][3] = 1'b1; mp[7][9] = 1'b1; send_frame(0, -1);
    rand_map(25); send_frame(0, 5);
    rand_map(25); send_frame(0, -1);
    clear_map(); mp[4][2] = 1'b1; mp[8][12] = 1'b1; mp[6][7] = 1'b1; send_frame(1, -1);
    repeat (8) begin
      rand_map($urandom_range(0, 3) == 0 ? 1 : $urandom_range(2, 30));
      send_frame(1'($urandom_range(0, 1)), -1);
    end
    repeat (4) step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) chk("drain", 96'(q.size()), 96'(0));
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
